// File: rtl/multicycle_addsub.sv
// multicycle_addsub: WIDTH-bit adder/subtractor that processes CHUNK bits per clock.
// The carry is held in a register between chunks. A start/busy/done handshake frames each operation.
module multicycle_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state, state_next;
    logic [WIDTH-1:0] a_r, b_r, s_next;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [CHUNK:0]   part;
    logic             last;
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_next;
    always_comb begin
        part       = {1'b0, a_r[int'(idx)*CHUNK +: CHUNK]} + {1'b0, b_r[int'(idx)*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry};
        s_next     = S;
        s_next[int'(idx)*CHUNK +: CHUNK] = part[CHUNK-1:0];
        last       = idx == IW'(N - 1);
        state_next = state == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
    end
    assign busy = state == RUN;
    // Operands are captured only in IDLE, so input changes or starts during RUN are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            done  <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
            V     <= 1'b0;
            Z     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                a_r   <= A;
                b_r   <= sub ? ~B : B;
                carry <= Cin;
                idx   <= '0;
            end else if (state == RUN) begin
                S     <= s_next;
                carry <= part[CHUNK];
                idx   <= last ? '0 : idx + 1'b1;
                if (last) begin
                    done <= 1'b1;
                    Cout <= part[CHUNK];
                    V    <= (a_r[WIDTH-1] == b_r[WIDTH-1]) & (s_next[WIDTH-1] != a_r[WIDTH-1]);
                    Z    <= ~|s_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_multicycle_addsub.sv
// tb_multicycle_addsub: directed and random checks of a 4-chunk and a single-chunk instance
// against an arithmetic reference model.
module tb_multicycle_addsub;
    logic             clk, rst, start, sub, Cin;
    logic [15:0]      A, B;
    logic [1:0]       busy_o, done_o, cout_o, v_o, z_o;
    logic [1:0][15:0] s_o;
    int               tests = 0, fails = 0;
    logic             chk_en = 0;
    int               rem [2];
    logic             m_done [2];
    logic [18:0]      m_res [2], p_res [2];

    multicycle_addsub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .busy(busy_o[0]), .done(done_o[0]), .S(s_o[0]), .Cout(cout_o[0]), .V(v_o[0]), .Z(z_o[0]));
    multicycle_addsub #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .busy(busy_o[1]), .done(done_o[1]), .S(s_o[1]), .Cout(cout_o[1]), .V(v_o[1]), .Z(z_o[1]));

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result packed as {V, Z, Cout, S}; V from the true signed sum falling outside 16-bit range.
    function automatic logic [18:0] calc(logic [15:0] a, logic [15:0] b, logic sb, logic ci);
        logic [15:0] be;
        logic [16:0] r;
        int          t;
        be = sb ? ~b : b;
        r  = {1'b0, a} + {1'b0, be} + 17'(ci);
        t  = int'($signed(a)) + int'($signed(be)) + int'(ci);
        return {t > 32767 || t < -32768, r[15:0] == 16'h0, r[16], r[15:0]};
    endfunction

    always @(posedge clk)
        for (int i = 0; i < 2; i++)
            if (rst) begin
                rem[i]    <= 0;
                m_done[i] <= 1'b0;
                m_res[i]  <= '0;
            end else begin
                m_done[i] <= 1'b0;
                if (rem[i] == 0) begin
                    if (start) begin
                        rem[i]   <= i == 0 ? 4 : 1;
                        p_res[i] <= calc(A, B, sub, Cin);
                    end
                end else begin
                    rem[i] <= rem[i] - 1;
                    if (rem[i] == 1) begin
                        m_done[i] <= 1'b1;
                        m_res[i]  <= p_res[i];
                    end
                end
            end

    always @(negedge clk)
        if (chk_en)
            for (int j = 0; j < 2; j++) begin
                check(j == 0 ? "busy0" : "busy1", 32'(busy_o[j]), 32'(rem[j] != 0));
                check(j == 0 ? "done0" : "done1", 32'(done_o[j]), 32'(m_done[j]));
                if (rem[j] == 0) check(j == 0 ? "s0" : "s1", 32'(s_o[j]), 32'(m_res[j][15:0]));
                check(j == 0 ? "flags0" : "flags1", 32'({v_o[j], z_o[j], cout_o[j]}), 32'(m_res[j][18:16]));
            end

    task automatic op(int sel, logic [15:0] a, logic [15:0] b, logic sb, logic ci,
                      logic [15:0] es, logic ec, logic ev, logic ez, string nm);
        int cyc = 0, bc = 0;
        A = a; B = b; sub = sb; Cin = ci; start = 1;
        do begin
            @(negedge clk);
            start = 0;
            cyc++;
            if (busy_o[sel]) bc++;
        end while (!done_o[sel] && cyc < 20);
        check({nm, "_latency"}, 32'(cyc - 1), sel == 0 ? 4 : 1);
        check({nm, "_busycycles"}, 32'(bc), sel == 0 ? 4 : 1);
        check({nm, "_S"}, 32'(s_o[sel]), 32'(es));
        check({nm, "_CVZ"}, 32'({cout_o[sel], v_o[sel], z_o[sel]}), 32'({ec, ev, ez}));
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int         nd;
        logic [15:0] sv;
        rst = 1; start = 0; sub = 0; Cin = 0; A = '0; B = '0;
        check("pin_ovf", 32'(calc(16'h7FFF, 16'h0001, 0, 0)), 32'({3'b100, 16'h8000}));
        check("pin_sub", 32'(calc(16'h0003, 16'h0007, 1, 1)), 32'({3'b000, 16'hFFFC}));
        check("pin_neg", 32'(calc(16'h8000, 16'h0001, 1, 1)), 32'({3'b101, 16'h7FFF}));
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++)
            check("reset_state", 32'({busy_o[i], done_o[i], s_o[i], cout_o[i], v_o[i], z_o[i]}), 32'h0);
        rst = 0;
        chk_en = 1;
        op(0, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0, "t1");
        op(0, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1, "t2");
        op(0, 16'h0007, 16'h0003, 1, 1, 16'h0004, 1, 0, 0, "t3a");
        op(0, 16'h0003, 16'h0007, 1, 1, 16'hFFFC, 0, 0, 0, "t3b");
        // start pulsed while busy must be ignored
        A = 16'h1234; B = 16'h1111; sub = 0; Cin = 0; start = 1;
        @(negedge clk); start = 0;
        @(negedge clk); A = 16'hFFFF; start = 1;
        @(negedge clk); start = 0;
        nd = 0; sv = '0;
        repeat (10) begin
            @(negedge clk);
            if (done_o[0]) begin nd++; sv = s_o[0]; end
        end
        check("t4_done_count", 32'(nd), 1);
        check("t4_S", 32'(sv), 32'h2345);
        // reset aborts an in-flight operation
        A = 16'h0F0F; B = 16'h0101; start = 1;
        @(negedge clk); start = 0;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        check("t5_after_rst", 32'({busy_o[0], done_o[0], s_o[0]}), 32'h0);
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_o[0]) nd++;
        end
        check("t5_no_done", 32'(nd), 0);
        op(0, 16'h0F0F, 16'h0101, 0, 0, 16'h1010, 0, 0, 0, "t5_fresh");
        op(1, 16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1, 1, "t6");
        for (int k = 0; k < 600; k++) begin
            A = 16'($urandom); B = 16'($urandom);
            sub = 1'($urandom); Cin = 1'($urandom);
            start = $urandom_range(0, 2) == 0;
            rst = $urandom_range(0, 63) == 0;
            @(negedge clk);
        end
        rst = 0; start = 0;
        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
